// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   Register word indices (address bits [4:2]), the FSM state type and the ID width.
//   An ID of 0 means "no interrupt". Source k reports as ID k+1.
package irq_pkg;

    localparam int N_IRQ_MAX = 31;
    localparam int ID_W      = 5;

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_EDGE    = 3'd2;
    localparam logic [2:0] REG_CLAIM   = 3'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } irq_state_e;

    typedef logic [ID_W-1:0] irq_id_t;

endpackage

// File: rtl/irq_if.sv
// APB bus bundle for the interrupt controller.
//   PCLK / PRESETn : clock and asynchronous active-low reset, carried with the bus
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : driven by the master
//   PRDATA, PREADY : driven by the slave
interface irq_if (
    input logic PCLK,
    input logic PRESETn
);
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  PCLK, PRESETn, PRDATA, PREADY,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder.
//   req : request vector (already masked)
//   id  : index+1 of the lowest set bit, 0 when no bit is set
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output irq_id_t          id
);

    // Scan from the top so the lowest set index is the last to assign.
    always_comb begin
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i + 1);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// APB-programmable interrupt controller.
//   apb_bus  : APB slave (PCLK/PRESETn carried in the bundle), zero wait states
//   irq_i    : interrupt request lines, synchronous to PCLK
//   irq_o    : interrupt request to the core
//   irq_id_o : ID of the highest-priority pending and enabled source, 0 if none
//
// state   | meaning
// IDLE    | no interrupt in service; irq_o follows pending & mask, CLAIM read claims
// SERVICE | one ID claimed; irq_o held low until matching COMPLETE write
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    irq_if.slave             apb_bus,
    input  logic [N_IRQ-1:0] irq_i,
    output logic             irq_o,
    output logic [ID_W-1:0]  irq_id_o
);

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] edge_q, edge_d;
    logic [N_IRQ-1:0] prev_q;
    irq_state_e       state_q, state_d;
    irq_id_t          claimed_id_q, claimed_id_d;

    logic             access, rd, wr;
    logic [2:0]       idx;
    logic [N_IRQ-1:0] wdata_bits;
    logic [N_IRQ-1:0] edge_set, w1c, claim_clr, edge_off;
    logic             claim_fire, complete_fire;
    logic [31:0]      rdata;
    logic             unused_bus;

    assign access     = apb_bus.PSEL && apb_bus.PENABLE;
    assign rd         = access && !apb_bus.PWRITE;
    assign wr         = access && apb_bus.PWRITE;
    assign idx        = apb_bus.PADDR[4:2];
    assign wdata_bits = apb_bus.PWDATA[N_IRQ-1:0];
    assign unused_bus = ^{apb_bus.PADDR[31:5], apb_bus.PADDR[1:0], apb_bus.PWDATA[31:N_IRQ]};

    assign apb_bus.PREADY = access;
    assign apb_bus.PRDATA = rdata;

    irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
        .req (pending_q & mask_q),
        .id  (irq_id_o)
    );

    assign irq_o         = (state_q == IDLE) && |(pending_q & mask_q);
    assign claim_fire    = rd && (idx == REG_CLAIM) && (state_q == IDLE) && (irq_id_o != '0);
    assign complete_fire = wr && (idx == REG_CLAIM) && (state_q == SERVICE) &&
                           (apb_bus.PWDATA[ID_W-1:0] == claimed_id_q);

    always_comb begin
        state_d      = state_q;
        claimed_id_d = claimed_id_q;
        case (state_q)
            IDLE: begin
                if (claim_fire) begin
                    state_d      = SERVICE;
                    claimed_id_d = irq_id_o;
                end
            end
            SERVICE: begin
                if (complete_fire) begin
                    state_d      = IDLE;
                    claimed_id_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d    = mask_q;
        edge_d    = edge_q;
        w1c       = '0;
        edge_off  = '0;
        claim_clr = '0;
        edge_set  = irq_i & ~prev_q & edge_q;
        if (wr) begin
            case (idx)
                REG_PENDING: w1c = wdata_bits;
                REG_MASK:    mask_d = wdata_bits;
                REG_EDGE: begin
                    edge_d   = wdata_bits;
                    edge_off = edge_q & ~wdata_bits;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < N_IRQ; i++) begin
            claim_clr[i] = claim_fire && (irq_id_o == ID_W'(i + 1));
        end
        // Edge bits: clears first, then a fresh edge re-sets (set wins).
        // Level bits: plain registered copy of the line.
        pending_d = (edge_q & ((pending_q & ~w1c & ~claim_clr) | edge_set)) |
                    (~edge_q & irq_i);
        // Leaving edge mode drops whatever was latched.
        pending_d = pending_d & ~edge_off;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (idx)
                REG_PENDING: rdata[N_IRQ-1:0] = pending_q;
                REG_MASK:    rdata[N_IRQ-1:0] = mask_q;
                REG_EDGE:    rdata[N_IRQ-1:0] = edge_q;
                REG_CLAIM:   rdata[ID_W-1:0]  = (state_q == IDLE) ? irq_id_o : '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge apb_bus.PCLK or negedge apb_bus.PRESETn) begin
        if (!apb_bus.PRESETn) begin
            pending_q    <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            prev_q       <= '0;
            state_q      <= IDLE;
            claimed_id_q <= '0;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            prev_q       <= irq_i;
            state_q      <= state_d;
            claimed_id_q <= claimed_id_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by a random
// phase, all checked against a per-bit behavioural model of the register rules.
module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq;
    logic         irq_o;
    logic [4:0]   irq_id;
    logic [31:0]  d;

    irq_if bus (.PCLK(clk), .PRESETn(rst_n));

    irq_ctrl #(.N_IRQ(N)) dut (
        .apb_bus  (bus),
        .irq_i    (irq),
        .irq_o    (irq_o),
        .irq_id_o (irq_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit [N-1:0] m_pend, m_mask, m_edge, m_prev;
    bit         m_svc;
    int         m_claimed;

    function automatic int m_id();
        for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_irq();
        return (!m_svc && m_id() != 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_read(int idx);
        case (idx)
            0: return 32'(m_pend);
            1: return 32'(m_mask);
            2: return 32'(m_edge);
            3: return m_svc ? 32'd0 : 32'(m_id());
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
        m_svc = 1'b0; m_claimed = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: model evaluates the rules on the pre-edge inputs, then both advance.
    task automatic tick();
        bit acc, rd, wr;
        int idx, id, nc;
        bit [N-1:0] np, nm, ne, pre;
        bit ns;
        acc = bus.PSEL && bus.PENABLE;
        rd  = acc && !bus.PWRITE;
        wr  = acc && bus.PWRITE;
        idx = int'(bus.PADDR[4:2]);
        id  = m_id();
        pre = irq;
        np = m_pend; nm = m_mask; ne = m_edge; ns = m_svc; nc = m_claimed;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (wr && idx == 0 && bus.PWDATA[i]) np[i] = 1'b0;
                if (rd && idx == 3 && !m_svc && id == i + 1) np[i] = 1'b0;
                if (irq[i] && !m_prev[i]) np[i] = 1'b1;
                if (wr && idx == 2 && !bus.PWDATA[i]) np[i] = 1'b0;
            end else begin
                np[i] = irq[i];
            end
        end
        if (wr && idx == 1) nm = bus.PWDATA[N-1:0];
        if (wr && idx == 2) ne = bus.PWDATA[N-1:0];
        if (!m_svc && rd && idx == 3 && id != 0) begin
            ns = 1'b1; nc = id;
        end else if (m_svc && wr && idx == 3 && int'(bus.PWDATA[4:0]) == m_claimed) begin
            ns = 1'b0; nc = 0;
        end
        @(posedge clk);
        #1;
        m_pend = np; m_mask = nm; m_edge = ne; m_prev = pre;
        m_svc = ns; m_claimed = nc;
        chk("irq_o", 32'(irq_o), m_irq());
        chk("irq_id_o", 32'(irq_id), 32'(m_id()));
    endtask

    task automatic bus_idle();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_write(int idx, logic [31:0] data);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = 32'(idx * 4); bus.PWDATA = data;
        #1 chk("pready_setup", 32'(bus.PREADY), 32'd0);
        tick();
        bus.PENABLE = 1'b1;
        #1 chk("pready_access", 32'(bus.PREADY), 32'd1);
        tick();
        bus_idle();
    endtask

    task automatic apb_read(int idx, output logic [31:0] data);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0;
        bus.PADDR = 32'(idx * 4);
        #1 chk("prdata_setup", bus.PRDATA, 32'd0);
        tick();
        bus.PENABLE = 1'b1;
        #1;
        data = bus.PRDATA;
        chk($sformatf("read_idx%0d", idx), data, m_read(idx));
        tick();
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int op, id;
        irq = '0;
        bus_idle();
        bus.PADDR = '0; bus.PWDATA = '0;
        m_reset();

        // Reset state
        #2;
        chk("rst_irq_o", 32'(irq_o), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            apb_read(r, d);
            chk("rst_reg", d, 32'd0);
        end

        // 1: single edge source
        apb_write(2, 32'h1);
        apb_write(1, 32'h1);
        irq = 8'h01;
        tick();
        irq = '0;
        chk("t1_irq_o", 32'(irq_o), 32'd1);
        chk("t1_id", 32'(irq_id), 32'd1);
        apb_read(0, d); chk("t1_pending", d, 32'h1);
        apb_read(3, d); chk("t1_claim", d, 32'd1);
        apb_read(0, d); chk("t1_pending_clr", d, 32'h0);
        chk("t1_irq_o_svc", 32'(irq_o), 32'd0);
        apb_write(3, 32'd1);
        chk("t1_irq_o_done", 32'(irq_o), 32'd0);

        // 2: priority between two edges
        apb_write(2, 32'hFF);
        apb_write(1, 32'hA);
        irq = 8'b0000_1010;
        tick();
        irq = '0;
        tick();
        chk("t2_id", 32'(irq_id), 32'd2);
        apb_read(3, d); chk("t2_claim2", d, 32'd2);
        apb_write(3, 32'd2);
        chk("t2_irq_o", 32'(irq_o), 32'd1);
        chk("t2_id4", 32'(irq_id), 32'd4);
        apb_read(3, d); chk("t2_claim4", d, 32'd4);
        apb_write(3, 32'd4);

        // 3: level source
        apb_write(2, 32'hFB);
        apb_write(1, 32'h4);
        irq = 8'h04;
        tick();
        tick();
        chk("t3_irq_o", 32'(irq_o), 32'd1);
        apb_read(3, d); chk("t3_claim", d, 32'd3);
        chk("t3_irq_o_svc", 32'(irq_o), 32'd0);
        apb_write(3, 32'd3);
        chk("t3_irq_o_again", 32'(irq_o), 32'd1);
        irq = '0;
        tick();
        chk("t3_irq_o_drop", 32'(irq_o), 32'd0);
        apb_read(0, d); chk("t3_pending", d, 32'h0);

        // 4: W1C coincident with new edge; mismatched complete
        apb_write(2, 32'hFF);
        apb_write(1, 32'h1);
        apb_write(0, 32'hFF);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = 32'h0; bus.PWDATA = 32'h1;
        tick();
        bus.PENABLE = 1'b1;
        irq = 8'h01;
        tick();
        bus_idle();
        irq = '0;
        apb_read(0, d); chk("t4_set_wins", d & 32'h1, 32'h1);
        apb_read(3, d); chk("t4_claim", d, 32'd1);
        apb_write(3, 32'd5);
        apb_read(3, d); chk("t4_still_svc", d, 32'd0);
        chk("t4_irq_o", 32'(irq_o), 32'd0);
        apb_write(3, 32'd1);

        // 5: masking and addressing
        apb_write(1, 32'h0);
        irq = 8'h03;
        tick();
        irq = '0;
        apb_read(0, d); chk("t5_pending", d, 32'h3);
        chk("t5_irq_o", 32'(irq_o), 32'd0);
        chk("t5_id", 32'(irq_id), 32'd0);
        apb_read(3, d); chk("t5_claim0", d, 32'd0);
        apb_write(6, 32'hFFFF_FFFF);
        apb_read(6, d); chk("t5_idx6", d, 32'd0);
        apb_write(1, 32'hFFFF_FFFF);
        apb_read(1, d); chk("t5_mask_width", d, 32'hFF);
        apb_write(1, 32'h0);

        // 6: reset during service
        apb_write(1, 32'h3);
        apb_read(3, d); chk("t6_claim", d, 32'd1);
        chk("t6_id_tracks", 32'(irq_id), 32'd2);
        rst_n = 1'b0;
        #2;
        m_reset();
        chk("t6_irq_o_async", 32'(irq_o), 32'd0);
        chk("t6_id_async", 32'(irq_id), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            apb_read(r, d);
            chk("t6_reg", d, 32'd0);
        end

        // Random phase
        for (int k = 0; k < 400; k++) begin
            irq = N'($urandom & $urandom);
            op = int'($urandom_range(0, 7));
            case (op)
                0: tick();
                1: apb_read(int'($urandom_range(0, 7)), d);
                2: apb_write(1, $urandom);
                3: apb_write(2, $urandom);
                4: apb_write(0, $urandom);
                5, 6: apb_read(3, d);
                default: begin
                    id = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : m_claimed;
                    apb_write(3, 32'(id));
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
